vc_credit_return_queue: RTL and testbench

Receive-side companion to the fixed-latency register delay line: it sits at the output of a NUM_CYCLES-deep pipeline and gives back-pressure to a pipeline that has none. It hands out issue credits to the producer and captures every result that leaves the pipeline in a DEPTH-entry circular queue. It returns each credit when the consumer dequeues, so results are never dropped while the downstream consumer stalls.

---
 rtl/vc_credit_return_queue_pkg.sv | 11 +
 rtl/vc_circ_queue.sv | 84 ++++++++
 rtl/vc_tools_reg_rst.sv | 26 ++
 rtl/vc_credit_return_queue.sv | 95 +++++++++
 tb/tb_vc_credit_return_queue.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/vc_credit_return_queue_pkg.sv
// Shared helpers for the credit-return queue slice.
// Ports: none (package only).
// Provides width clamping so degenerate parameters never yield zero-width vectors.
package vc_credit_return_queue_pkg;

    // $clog2 returns 0 for a single-entry structure; a vector still needs one bit.
    function automatic int clamp_w(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vc_circ_queue.sv
// Purpose: DEPTH-entry circular FIFO with registered head (storage, pointers, count).
// Latency: 1 cycle enq to deq_val; deq_data is mem[rd_ptr] with no bypass.
// Backpressure: deq_rdy stalls the head; enq while full is dropped unless a deq fires the same cycle.
// Ports: enq_val/enq_data in, deq_val/deq_rdy/deq_data out, full and count status.
module vc_circ_queue
    import vc_credit_return_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enq_val,
    input  logic [DATA_WIDTH-1:0]             enq_data,
    output logic                              deq_val,
    input  logic                              deq_rdy,
    output logic [DATA_WIDTH-1:0]             deq_data,
    output logic                              full,
    output logic [clamp_w($clog2(DEPTH+1))-1:0] count
);

    localparam int PW = clamp_w($clog2(DEPTH));
    localparam int CW = clamp_w($clog2(DEPTH+1));

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  enq_fire, deq_fire;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        deq_fire = (count_q != '0) && deq_rdy;
        // A dequeue reads the old head, so a write into a full queue is safe
        // when the head leaves in the same cycle.
        enq_fire = enq_val && ((count_q != CW'(DEPTH)) || deq_fire);

        if (enq_fire) begin
            mem_d[wr_ptr_q] = enq_data;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (deq_fire) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (enq_fire && !deq_fire) begin
            count_d = count_q + CW'(1);
        end else if (deq_fire && !enq_fire) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; contents are only observed behind count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign deq_val  = (count_q != '0);
    assign deq_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;

endmodule

// File: rtl/vc_tools_reg_rst.sv
// Purpose: plain register with synchronous active-high reset to a parameterised value.
// Latency: 1 cycle, d to q.
// Backpressure: none; loads d every cycle. Ports: clk, reset, d, q.
module vc_tools_reg_rst #(
    parameter int          W           = 1,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= W'(RESET_VALUE);
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/vc_credit_return_queue.sv
// Purpose: credit-gated receive queue behind a fixed-latency pipeline with no backpressure.
// Latency: issue at t -> pipe_val at t+NUM_CYCLES -> deq_val at t+NUM_CYCLES+1.
// Backpressure: issue_rdy drops when credits hit 0; a credit returns on each deq fire.
// Ports: issue_val/issue_rdy (producer), pipe_val/pipe_data (pipeline output),
//        deq_val/deq_rdy/deq_msg (consumer), credits and sticky overflow status.
module vc_credit_return_queue
    import vc_credit_return_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_CYCLES = 1,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_val,
    output logic                         issue_rdy,
    input  logic                         pipe_val,
    input  logic [DATA_WIDTH-1:0]        pipe_data,
    output logic                         deq_val,
    input  logic                         deq_rdy,
    output logic [DATA_WIDTH-1:0]        deq_msg,
    output logic [$clog2(DEPTH+1)-1:0]   credits,
    output logic                         overflow
);

    localparam int CW = clamp_w($clog2(DEPTH+1));
    localparam int DW = clamp_w($clog2(NUM_CYCLES+1));

    logic [CW-1:0] credits_q, credits_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          overflow_q, overflow_d;
    logic          issue_fire, deq_fire, pipe_acc;
    logic          q_deq_val, q_full;
    logic [CW-1:0] q_count;

    always_comb begin
        issue_fire = issue_val && issue_rdy;
        deq_fire   = q_deq_val && deq_rdy;

        credits_d = credits_q;
        if (issue_fire && !deq_fire) begin
            credits_d = credits_q - CW'(1);
        end else if (deq_fire && !issue_fire && (credits_q != CW'(DEPTH))) begin
            credits_d = credits_q + CW'(1);
        end

        // The delay line upstream has no reset, so anything it emits in the
        // first NUM_CYCLES cycles after reset is stale and must be squashed.
        drain_d  = (drain_q != '0) ? drain_q - DW'(1) : '0;
        pipe_acc = pipe_val && !reset && (drain_q == '0);

        overflow_d = overflow_q || (pipe_acc && q_full && !deq_fire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q  <= CW'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    vc_tools_reg_rst #(
        .W           (DW),
        .RESET_VALUE (NUM_CYCLES)
    ) u_drain_reg (
        .clk   (clk),
        .reset (reset),
        .d     (drain_d),
        .q     (drain_q)
    );

    vc_circ_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (pipe_acc),
        .enq_data (pipe_data),
        .deq_val  (q_deq_val),
        .deq_rdy  (deq_rdy),
        .deq_data (deq_msg),
        .full     (q_full),
        .count    (q_count)
    );

    assign issue_rdy = (credits_q != '0);
    assign deq_val   = (q_count != '0);
    assign credits   = credits_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_vc_credit_return_queue.sv
// Bench for vc_credit_return_queue: delay line between issue and pipe_val,
// scoreboard of expected results in issue order, monitor comparing each cycle.
module tb_vc_credit_return_queue;

    localparam int N   = 3;
    localparam int D   = 5;
    localparam int W   = 12;
    localparam int CWB = $clog2(D+1);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           issue_val = 1'b0;
    logic           issue_rdy;
    logic           pipe_val;
    logic [W-1:0]   pipe_data;
    logic           deq_val;
    logic           deq_rdy = 1'b0;
    logic [W-1:0]   deq_msg;
    logic [CWB-1:0] credits;
    logic           overflow;

    logic [W-1:0]   issue_data = '0;
    logic           force_val = 1'b0;
    logic [W-1:0]   force_data = '0;

    vc_credit_return_queue #(
        .DATA_WIDTH (W),
        .NUM_CYCLES (N),
        .DEPTH      (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .issue_val (issue_val),
        .issue_rdy (issue_rdy),
        .pipe_val  (pipe_val),
        .pipe_data (pipe_data),
        .deq_val   (deq_val),
        .deq_rdy   (deq_rdy),
        .deq_msg   (deq_msg),
        .credits   (credits),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Non-resettable fixed-latency delay line feeding the DUT.
    logic [N-1:0] dl_val = '0;
    logic [W-1:0] dl_dat [N];
    always @(posedge clk) begin
        dl_val    <= {dl_val[N-2:0], issue_val && issue_rdy};
        dl_dat[0] <= issue_data;
        for (int i = 1; i < N; i++) dl_dat[i] <= dl_dat[i-1];
    end
    assign pipe_val  = dl_val[N-1] | force_val;
    assign pipe_data = force_val ? force_data : dl_dat[N-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: results in order with the cycle they reach the queue.
    typedef struct {
        logic [W-1:0] dat;
        int           arr;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_err = 0;
    int exp_credits = D;
    bit exp_ovf = 1'b0;
    bit ovf_evt = 1'b0;
    int last_rst = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; records what the DUT should eventually produce.
    task automatic drive(input logic iv, input logic dr, input logic fv, input logic rst,
                         input logic [W-1:0] idat, input logic [W-1:0] fdat);
        int in_q;
        @(negedge clk);
        issue_val = iv; deq_rdy = dr; force_val = fv; reset = rst;
        issue_data = idat; force_data = fdat;
        #1;
        if (rst) begin
            exp_q.delete();
            last_rst = cyc;
        end else begin
            if (fv && (cyc - last_rst > N)) begin
                in_q = 0;
                foreach (exp_q[k]) if (exp_q[k].arr < cyc) in_q++;
                if (in_q == D && !dr) ovf_evt = 1'b1;
                else exp_q.push_back('{fdat, cyc});
            end
            if (iv && issue_rdy) exp_q.push_back('{idat, cyc + N});
        end
    endtask

    // Monitor: compares state every cycle and pops on each dequeue.
    initial begin
        exp_t h;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                exp_credits = D;
                exp_ovf = 1'b0;
                ovf_evt = 1'b0;
                continue;
            end
            check("credits", int'(credits), exp_credits);
            check("issue_rdy", int'(issue_rdy), int'(exp_credits != 0));
            check("deq_val", int'(deq_val), int'(exp_q.size() > 0 && exp_q[0].arr < cyc));
            check("overflow", int'(overflow), int'(exp_ovf));
            if (deq_val && deq_rdy) begin
                if (exp_q.size() == 0) begin
                    check("deq_unexpected", 1, 0);
                end else begin
                    h = exp_q.pop_front();
                    check("deq_msg", int'(deq_msg), int'(h.dat));
                end
            end
            if (issue_val && issue_rdy && !(deq_val && deq_rdy)) exp_credits--;
            else if (deq_val && deq_rdy && !(issue_val && issue_rdy) && exp_credits < D)
                exp_credits++;
            if (ovf_evt) begin
                exp_ovf = 1'b1;
                ovf_evt = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, '0, '0);
        for (int i = 0; i < N + 1; i++) drive(0, 0, 0, 0, '0, '0);

        // Back-to-back streaming with the consumer always ready.
        for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, W'(i), '0);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, '0, '0);

        // Fill with a stalled consumer: credits run out, queue fills.
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 0, W'(100 + i), '0);
        // One dequeue frees one credit; the refill arrives N cycles later.
        drive(1, 1, 0, 0, W'(200), '0);
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, W'(201 + i), '0);

        // Pipe result into a full queue with no dequeue: dropped, overflow sticks.
        drive(0, 0, 1, 0, '0, W'(12'hBAD));
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, '0, '0);
        // Simultaneous dequeue and pipe result at full: accepted at the tail.
        drive(0, 1, 1, 0, '0, W'(12'h5A5));
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, '0, '0);

        // Reset with two results queued and two still in the delay line.
        drive(1, 0, 0, 0, W'(300), '0);
        drive(1, 0, 0, 0, W'(301), '0);
        drive(0, 0, 0, 0, '0, '0);
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, W'(302), '0);
        drive(1, 0, 0, 0, W'(303), '0);
        drive(0, 0, 0, 1, '0, '0);
        // Stray pipe valids inside the drain window are ignored; issues proceed.
        for (int i = 0; i < N; i++) drive(1, 1, 1, 0, W'(400 + i), W'(12'hEEE));
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, '0, '0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0)
                drive(0, 0, 0, 1, '0, '0);
            else
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 0, 0,
                      W'($urandom), '0);
        end
        for (int i = 0; i < 15; i++) drive(0, 1, 0, 0, '0, '0);

        @(negedge clk);
        #3;
        check("final_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
